// File: rtl/rvb_pcpi_hub_pkg.sv
// Shared definitions for the PCPI hub: state encoding, limits and the
// helper that sizes the claim timeout counter.
package rvb_pcpi_hub_pkg;

    localparam int NCP_MAX = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CLAIMED = 3'd2,
        ST_RESP    = 3'd3,
        ST_DRAIN   = 3'd4
    } hub_state_t;

    // Counter holds 0..timeout-1.
    function automatic int cnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/rvb_pcpi_hub_prio.sv
// Lowest-index priority encoder.
// Ports: req (N bits) in; gnt one-hot out; any = at least one request.
module rvb_pcpi_hub_prio #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         any
);

    // Two's complement isolates the lowest set bit.
    assign gnt = req & (~req + N'(1));
    assign any = |req;

endmodule

// File: rtl/rvb_pcpi_hub.sv
// PCPI hub: registers the core request, broadcasts it to NCP coprocessors,
// tracks the claiming port, returns the registered response, and drops an
// unclaimed instruction after TIMEOUT cycles.
// Ports: clk/resetn (sync, active-low); pcpi_* core side; cp_* coprocessor
// side (cp_rd port i at [i*XLEN +: XLEN]).
// Build option RVB_PCPI_HUB_STATS_EN adds stat_issued/done/timeout/conflict.
module rvb_pcpi_hub
    import rvb_pcpi_hub_pkg::*;
#(
    parameter int NCP     = 2,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 12
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                pcpi_valid,
    input  logic [31:0]         pcpi_insn,
    input  logic [XLEN-1:0]     pcpi_rs1,
    input  logic [XLEN-1:0]     pcpi_rs2,
    input  logic [XLEN-1:0]     pcpi_rs3,
    output logic                pcpi_wr,
    output logic [XLEN-1:0]     pcpi_rd,
    output logic                pcpi_wait,
    output logic                pcpi_ready,
    output logic [NCP-1:0]      cp_valid,
    output logic [31:0]         cp_insn,
    output logic [XLEN-1:0]     cp_rs1,
    output logic [XLEN-1:0]     cp_rs2,
    output logic [XLEN-1:0]     cp_rs3,
    input  logic [NCP-1:0]      cp_wr,
    input  logic [NCP*XLEN-1:0] cp_rd,
    input  logic [NCP-1:0]      cp_wait,
    input  logic [NCP-1:0]      cp_ready
`ifdef RVB_PCPI_HUB_STATS_EN
    ,
    output logic [31:0]         stat_issued,
    output logic [31:0]         stat_done,
    output logic [31:0]         stat_timeout,
    output logic [31:0]         stat_conflict
`endif
);

    localparam int CW = cnt_width(TIMEOUT);

    hub_state_t       state;
    logic [CW-1:0]    cnt;
    logic [NCP-1:0]   owner;

    logic [NCP-1:0]   rdy_gnt;
    logic             rdy_any;
    logic [NCP-1:0]   wt_gnt;
    logic             wt_any;

    logic [NCP-1:0]   win;
    logic             owner_rdy;
    logic [XLEN-1:0]  rd_sel;
    logic             wr_sel;
    logic             to_hit;

    rvb_pcpi_hub_prio #(.N(NCP)) u_prio_rdy (
        .req (cp_ready),
        .gnt (rdy_gnt),
        .any (rdy_any)
    );

    rvb_pcpi_hub_prio #(.N(NCP)) u_prio_wt (
        .req (cp_wait),
        .gnt (wt_gnt),
        .any (wt_any)
    );

    // A latched owner overrides the lowest-ready choice.
    assign win       = (state == ST_CLAIMED) ? owner : rdy_gnt;
    assign owner_rdy = |(owner & cp_ready);
    assign to_hit    = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        rd_sel = '0;
        wr_sel = 1'b0;
        for (int i = 0; i < NCP; i++) begin
            if (win[i]) begin
                rd_sel = rd_sel | cp_rd[i*XLEN +: XLEN];
                wr_sel = wr_sel | cp_wr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            owner      <= '0;
            cp_valid   <= '0;
            cp_insn    <= '0;
            cp_rs1     <= '0;
            cp_rs2     <= '0;
            cp_rs3     <= '0;
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= '0;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b0;
        end else begin
            pcpi_ready <= 1'b0;
            pcpi_wait  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pcpi_valid) begin
                        cp_insn  <= pcpi_insn;
                        cp_rs1   <= pcpi_rs1;
                        cp_rs2   <= pcpi_rs2;
                        cp_rs3   <= pcpi_rs3;
                        cnt      <= '0;
                        owner    <= '0;
                        cp_valid <= '1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt <= cnt + 1'b1;
                    if (!pcpi_valid) begin
                        cp_valid <= '0;
                        state    <= ST_IDLE;
                    end else if (rdy_any) begin
                        pcpi_rd    <= rd_sel;
                        pcpi_wr    <= wr_sel;
                        pcpi_ready <= 1'b1;
                        cp_valid   <= '0;
                        state      <= ST_RESP;
                    end else if (wt_any) begin
                        owner     <= wt_gnt;
                        pcpi_wait <= 1'b1;
                        state     <= ST_CLAIMED;
                    end else if (to_hit) begin
                        cp_valid <= '0;
                        state    <= ST_DRAIN;
                    end
                end
                ST_CLAIMED: begin
                    if (!pcpi_valid) begin
                        cp_valid <= '0;
                        state    <= ST_IDLE;
                    end else if (owner_rdy) begin
                        pcpi_rd    <= rd_sel;
                        pcpi_wr    <= wr_sel;
                        pcpi_ready <= 1'b1;
                        cp_valid   <= '0;
                        state      <= ST_RESP;
                    end else begin
                        pcpi_wait <= 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Wait for the core to drop valid so the same
                    // instruction is not captured twice.
                    if (!pcpi_valid) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RVB_PCPI_HUB_STATS_EN
    logic multi_rdy;
    logic multi_wt;

    assign multi_rdy = |(cp_ready & (cp_ready - NCP'(1)));
    assign multi_wt  = |(cp_wait & (cp_wait - NCP'(1)));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_issued   <= '0;
            stat_done     <= '0;
            stat_timeout  <= '0;
            stat_conflict <= '0;
        end else begin
            if (state == ST_IDLE && pcpi_valid)
                stat_issued <= stat_issued + 32'd1;
            if (state == ST_RESP)
                stat_done <= stat_done + 32'd1;
            if (state == ST_ISSUE && pcpi_valid && !rdy_any && !wt_any && to_hit)
                stat_timeout <= stat_timeout + 32'd1;
            if (multi_rdy || multi_wt)
                stat_conflict <= stat_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rvb_pcpi_hub.sv
// Testbench for rvb_pcpi_hub: per-transaction timeline plans with a response
// scoreboard checked by an independent monitor.
module tb_rvb_pcpi_hub;

    localparam int NCP  = 3;
    localparam int XLEN = 32;
    localparam int TO   = 12;
    localparam int PL   = 64;

    logic                clk;
    logic                resetn;
    logic                pcpi_valid;
    logic [31:0]         pcpi_insn;
    logic [XLEN-1:0]     pcpi_rs1, pcpi_rs2, pcpi_rs3;
    logic                pcpi_wr;
    logic [XLEN-1:0]     pcpi_rd;
    logic                pcpi_wait;
    logic                pcpi_ready;
    logic [NCP-1:0]      cp_valid;
    logic [31:0]         cp_insn;
    logic [XLEN-1:0]     cp_rs1, cp_rs2, cp_rs3;
    logic [NCP-1:0]      cp_wr;
    logic [NCP*XLEN-1:0] cp_rd;
    logic [NCP-1:0]      cp_wait;
    logic [NCP-1:0]      cp_ready;
`ifdef RVB_PCPI_HUB_STATS_EN
    logic [31:0] stat_issued, stat_done, stat_timeout, stat_conflict;
`endif

    rvb_pcpi_hub #(.NCP(NCP), .XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_rs3   (pcpi_rs3),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready),
        .cp_valid   (cp_valid),
        .cp_insn    (cp_insn),
        .cp_rs1     (cp_rs1),
        .cp_rs2     (cp_rs2),
        .cp_rs3     (cp_rs3),
        .cp_wr      (cp_wr),
        .cp_rd      (cp_rd),
        .cp_wait    (cp_wait),
        .cp_ready   (cp_ready)
`ifdef RVB_PCPI_HUB_STATS_EN
        ,
        .stat_issued   (stat_issued),
        .stat_done     (stat_done),
        .stat_timeout  (stat_timeout),
        .stat_conflict (stat_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [XLEN-1:0] rd;
        logic            wr;
        int unsigned     at;
    } exp_t;

    exp_t sbq[$];

    // Monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (pcpi_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ready", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("resp_rd", 64'(pcpi_rd), 64'(e.rd));
                chk("resp_wr", 64'(pcpi_wr), 64'(e.wr));
                chk("resp_cycle", 64'(cyc), 64'(e.at));
                chk("cpv_at_ready", 64'(cp_valid), 64'd0);
            end
        end
    end

    // Timeline plan for one transaction, indexed by cycle offset.
    logic            pv[PL];
    logic [NCP-1:0]  prdy[PL];
    logic [NCP-1:0]  pwt[PL];
    logic            prs[PL];
    logic            ecpv[PL];
    logic            ewait[PL];
    logic            erst[PL];

    logic [XLEN-1:0] rdv[NCP];
    logic [NCP-1:0]  wrv;

    int unsigned m_iss, m_done, m_to, m_conf;

    function automatic int lowest(input logic [NCP-1:0] m);
        for (int i = 0; i < NCP; i++)
            if (m[i]) return i;
        return 0;
    endfunction

    function automatic logic [NCP-1:0] bit_of(input int i);
        logic [NCP-1:0] b;
        b = '0;
        b[i] = 1'b1;
        return b;
    endfunction

    // mode: 0 direct ready, 1 claim then ready, 2 timeout,
    // 3 abort in ISSUE, 4 abort in CLAIMED, 5 reset in CLAIMED
    task automatic run(input int mode, input int d, input int j,
                       input int h, input logic [NCP-1:0] m,
                       input bit noise);
        int tr, own, win, ta, len;
        int unsigned c0;
        bit resp;
        logic [31:0] insn;
        logic [XLEN-1:0] r1, r2, r3;
        for (int t = 0; t < PL; t++) begin
            pv[t] = 0; prdy[t] = '0; pwt[t] = '0; prs[t] = 1;
            ecpv[t] = 0; ewait[t] = 0; erst[t] = 0;
        end
        tr = 0; win = 0; resp = 0; len = 4;
        own = lowest(m);
        case (mode)
            0: begin
                tr = 2 + d;
                win = own;
                resp = 1;
                for (int t = 0; t < tr + h; t++) pv[t] = 1;
                prdy[1 + d] = m;
                for (int t = 1; t <= 1 + d; t++) ecpv[t] = 1;
                len = tr + h + 3;
            end
            1: begin
                tr = 3 + d + j;
                win = own;
                resp = 1;
                for (int t = 0; t < tr + h; t++) pv[t] = 1;
                for (int t = 1 + d; t <= 2 + d + j; t++) pwt[t] = m;
                if (noise)
                    for (int t = 2 + d; t <= 1 + d + j; t++)
                        prdy[t] = NCP'($urandom) & ~bit_of(own);
                prdy[2 + d + j] = bit_of(own)
                                | (noise ? NCP'($urandom) : '0);
                for (int t = 1; t < tr; t++) ecpv[t] = 1;
                for (int t = 2 + d; t <= 2 + d + j; t++) ewait[t] = 1;
                len = tr + h + 3;
            end
            2: begin
                for (int t = 0; t <= TO + h; t++) pv[t] = 1;
                for (int t = 1; t <= TO; t++) ecpv[t] = 1;
                len = TO + h + 3;
                m_to++;
            end
            3: begin
                for (int t = 0; t < d; t++) pv[t] = 1;
                for (int t = 1; t <= d; t++) ecpv[t] = 1;
                prdy[d + 1] = m;
                if (noise) prdy[d + 2] = m;
                len = d + 4;
            end
            default: begin
                ta = 2 + d + j;
                for (int t = 0; t < ta; t++) pv[t] = 1;
                for (int t = 1 + d; t <= ta; t++) pwt[t] = m;
                for (int t = 1; t <= ta; t++) ecpv[t] = 1;
                for (int t = 2 + d; t <= ta; t++) ewait[t] = 1;
                if (mode == 4) begin
                    prdy[ta + 2] = bit_of(own);
                    len = ta + 4;
                end else begin
                    prs[ta] = 0;
                    erst[ta + 1] = 1;
                    len = ta + 3;
                end
            end
        endcase
        m_iss++;
        if (resp) m_done++;
        insn = $urandom;
        r1 = $urandom; r2 = $urandom; r3 = $urandom;
        for (int i = 0; i < NCP; i++) cp_rd[i*XLEN +: XLEN] = rdv[i];
        cp_wr = wrv;
        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            if (t == 0) begin
                c0 = cyc;
                if (resp) sbq.push_back('{rdv[win], wrv[win], c0 + tr});
            end
            chk("cp_valid", 64'(cp_valid), 64'({NCP{ecpv[t]}}));
            chk("pcpi_wait", 64'(pcpi_wait), 64'(ewait[t]));
            if (t == 1) begin
                chk("cp_insn", 64'(cp_insn), 64'(insn));
                chk("cp_rs1", 64'(cp_rs1), 64'(r1));
                chk("cp_rs2", 64'(cp_rs2), 64'(r2));
                chk("cp_rs3", 64'(cp_rs3), 64'(r3));
            end
            if (erst[t]) begin
                chk("rst_ready", 64'(pcpi_ready), 64'd0);
                chk("rst_rd", 64'(pcpi_rd), 64'd0);
                chk("rst_wr", 64'(pcpi_wr), 64'd0);
                chk("rst_insn", 64'(cp_insn), 64'd0);
                chk("rst_rs1", 64'(cp_rs1), 64'd0);
            end
            pcpi_valid = pv[t];
            pcpi_insn  = insn;
            pcpi_rs1   = r1;
            pcpi_rs2   = r2;
            pcpi_rs3   = r3;
            cp_ready   = prdy[t];
            cp_wait    = pwt[t];
            resetn     = prs[t];
            if (!prs[t]) begin
                m_iss = 0; m_done = 0; m_to = 0; m_conf = 0;
            end else if ($countones(prdy[t]) > 1 || $countones(pwt[t]) > 1) begin
                m_conf++;
            end
        end
    endtask

    task automatic rand_rd();
        for (int i = 0; i < NCP; i++) rdv[i] = $urandom;
        wrv = NCP'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int mode;
        logic [NCP-1:0] m;
        m_iss = 0; m_done = 0; m_to = 0; m_conf = 0;
        resetn = 0; pcpi_valid = 0; pcpi_insn = '0;
        pcpi_rs1 = '0; pcpi_rs2 = '0; pcpi_rs3 = '0;
        cp_wr = '0; cp_rd = '0; cp_wait = '0; cp_ready = '0;
        repeat (3) @(negedge clk);
        chk("reset_cp_valid", 64'(cp_valid), 64'd0);
        chk("reset_ready", 64'(pcpi_ready), 64'd0);
        chk("reset_wait", 64'(pcpi_wait), 64'd0);
        chk("reset_rd", 64'(pcpi_rd), 64'd0);
        chk("reset_wr", 64'(pcpi_wr), 64'd0);
        chk("reset_insn", 64'(cp_insn), 64'd0);
        resetn = 1;

        rand_rd(); rdv[1] = 32'hDEADBEEF; wrv[1] = 1'b1;
        run(1, 1, 2, 0, 3'b010, 0);
        rand_rd(); rdv[0] = 32'h5;
        run(0, 0, 0, 0, 3'b001, 0);
        rand_rd();
        run(2, 0, 0, 3, 3'b000, 0);
        rand_rd(); rdv[0] = 32'h11; rdv[1] = 32'h22;
        run(0, 3, 0, 1, 3'b011, 0);
        rand_rd();
        run(4, 0, 1, 0, 3'b001, 0);
        rand_rd();
        run(5, 2, 1, 0, 3'b010, 0);
        rand_rd();
        run(1, 0, 0, 0, 3'b100, 1);
        rand_rd();
        run(0, TO - 1, 0, 2, 3'b110, 0);

        for (int n = 0; n < 200; n++) begin
            rand_rd();
            mode = $urandom_range(0, 5);
            m = NCP'($urandom_range(1, (1 << NCP) - 1));
            case (mode)
                0: run(0, $urandom_range(0, TO - 1), 0,
                       $urandom_range(0, 3), m, 0);
                1: run(1, $urandom_range(0, TO - 1), $urandom_range(0, 15),
                       $urandom_range(0, 3), m, 1'($urandom));
                2: run(2, 0, 0, $urandom_range(1, 3), m, 0);
                3: run(3, $urandom_range(1, TO - 1), 0, 0, m, 1'($urandom));
                default: run(mode, $urandom_range(0, TO - 1),
                             $urandom_range(0, 4), 0, m, 0);
            endcase
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(sbq.size()), 64'd0);
`ifdef RVB_PCPI_HUB_STATS_EN
        chk("stat_issued", 64'(stat_issued), 64'(m_iss));
        chk("stat_done", 64'(stat_done), 64'(m_done));
        chk("stat_timeout", 64'(stat_timeout), 64'(m_to));
        chk("stat_conflict", 64'(stat_conflict), 64'(m_conf));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rvb_pcpi_hub.md
Name: rvb_pcpi_hub

Overview:
- Sits between the picorv32 core PCPI port and NCP PCPI coprocessors (rvb_pcpi worker, mul/div, ...). It feeds rvb_pcpi and collects its result.
- Registers the core request and broadcasts it to all coprocessors.
- Tracks which coprocessor claims the instruction, registers the response back to the core, and enforces its own claim timeout shorter than the core's 16-cycle limit.

Parameters:
- NCP, 2: number of coprocessor ports, 1..8.
- XLEN, 32: operand and result width.
- TIMEOUT, 12: cycles allowed in ISSUE with no cp_wait or cp_ready before the hub gives up. Legal range is 2..14.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- pcpi_valid  in  1  core request valid
- pcpi_insn  in  32  instruction word
- pcpi_rs1, pcpi_rs2, pcpi_rs3  in  XLEN each  operands
- pcpi_wr  out  1  result write enable
- pcpi_rd  out  XLEN  result
- pcpi_wait  out  1  instruction claimed
- pcpi_ready  out  1  response pulse
- cp_valid  out  NCP  per-port request valid, all bits equal
- cp_insn  out  32  registered instruction, shared by all ports
- cp_rs1, cp_rs2, cp_rs3  out  XLEN each  registered operands, shared
- cp_wr  in  NCP  per-port write enable
- cp_rd  in  NCP*XLEN  per-port result; port i occupies [i*XLEN +: XLEN]
- cp_wait  in  NCP  per-port claim
- cp_ready  in  NCP  per-port done

Behaviour:
- Reset is resetn, synchronous, active-low; clock is clk.
- Reset values:
  - state=IDLE.
  - All outputs 0: cp_valid, pcpi_wr, pcpi_ready, pcpi_wait, pcpi_rd, and the cp_insn/cp_rs* registers.
- States: IDLE, ISSUE, CLAIMED, RESP, DRAIN.
- IDLE:
  - pcpi_valid=1 → capture insn/rs1/rs2/rs3, clear the timeout counter, go to ISSUE.
  - Any cp_ready or cp_wait seen in IDLE is ignored.
- ISSUE:
  - cp_valid is all-ones; the counter increments every cycle.
  - Any cp_ready → go to RESP. This takes priority over wait and over timeout.
  - Otherwise any cp_wait → go to CLAIMED and latch the owner as the lowest set index.
  - Otherwise, when counter == TIMEOUT-1 → go to DRAIN with no response. The core then takes its own illegal-instruction path.
- CLAIMED:
  - cp_valid stays all-ones; pcpi_wait=1.
  - Owner's cp_ready → go to RESP.
  - cp_ready from a non-owner is ignored.
  - There is no timeout in this state.
- Entering RESP from cp_ready at cycle t:
  - The winner is the owner if one is latched, otherwise the lowest set index.
  - Latch pcpi_rd = cp_rd[winner] and pcpi_wr = cp_wr[winner].
  - At t+1: cp_valid=0 (so the coprocessor busy flag sees no new request) and pcpi_ready=1 for exactly one cycle.
- RESP → DRAIN unconditionally after that single cycle.
- DRAIN:
  - Stays until pcpi_valid=0, then goes to IDLE.
  - This prevents re-capturing the same instruction while the core deasserts valid.
- Abort: pcpi_valid=0 in ISSUE or CLAIMED → go to IDLE next cycle with cp_valid=0. Any late cp_ready is discarded.
- pcpi_wait is registered: it is 1 in CLAIMED, 1 on the cycle a claim is latched, and 0 otherwise.
- pcpi_rd and pcpi_wr hold their value outside RESP; they are meaningful only while pcpi_ready=1.
- Latency: a coprocessor responding combinationally in its first cp_valid cycle gives pcpi_ready 2 cycles after pcpi_valid rises. Each additional coprocessor cycle adds 1.
- Multiple cp_ready or cp_wait bits in the same cycle: lowest index wins deterministically.
- Reset mid-operation returns to IDLE; no response is emitted.

Optional Feature:
- Macro: RVB_PCPI_HUB_STATS_EN.
- Defined: adds four 32-bit wrapping outputs, all reset to 0:
  - stat_issued: +1 on each IDLE→ISSUE.
  - stat_done: +1 on each RESP.
  - stat_timeout: +1 on each ISSUE→DRAIN timeout.
  - stat_conflict: +1 in any cycle where more than one bit of cp_ready or of cp_wait is set.
- Undefined: these ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- Package rvb_pcpi_hub_pkg:
  - State encoding constants (3-bit): IDLE=0, ISSUE=1, CLAIMED=2, RESP=3, DRAIN=4.
  - Function computing the timeout counter width from TIMEOUT.
  - NCP_MAX=8.
- One sub-module, rvb_pcpi_hub_prio: combinational lowest-index priority encoder. Input is an NCP-bit vector; outputs are a one-hot grant and a valid flag. It is instantiated for both cp_ready and cp_wait.

Test Plan:
- NCP=2, port 1 asserts cp_wait at cycle 2 and cp_ready with cp_rd=32'hDEADBEEF, cp_wr=1 at cycle 5 → pcpi_wait=1 from cycle 3; pcpi_ready=1, pcpi_rd=32'hDEADBEEF, pcpi_wr=1 at cycle 6 only; cp_valid=0 at cycle 6.
- Port 0 asserts cp_ready in its first cp_valid cycle with rd=32'h5 → pcpi_ready exactly 2 cycles after pcpi_valid rose; pcpi_wait never asserted.
- No port responds, TIMEOUT=12 → cp_valid drops after 12 ISSUE cycles with no pcpi_ready; hub stays in DRAIN while pcpi_valid=1 and reaches IDLE 1 cycle after pcpi_valid falls.
- Ports 0 and 1 both assert cp_ready in the same cycle, with rd=32'h11 and 32'h22 → pcpi_rd=32'h11; stat_conflict=1 when RVB_PCPI_HUB_STATS_EN is defined.
- pcpi_valid drops while CLAIMED, then port 0 raises cp_ready 2 cycles later → no pcpi_ready, state is IDLE, next request is captured normally.
- resetn low for 1 cycle during CLAIMED → all outputs 0 the next cycle; subsequent request completes with the correct rd.
